// File: rtl/serial_nibble_pkg.sv
// Shared constants, buffer state encoding and combinational helpers for the
// serial nibble receiver.
package serial_nibble_pkg;

    localparam int DATA_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // Number of strobed bits per frame: data bits plus an optional parity bit.
    function automatic int frame_len(input bit parity_en);
        return parity_en ? DATA_W + 1 : DATA_W;
    endfunction

    // arrival[k] holds the k-th received data bit; returns the word with bit 3 as MSB.
    function automatic logic [DATA_W-1:0] order_bits(input logic [DATA_W-1:0] arrival,
                                                     input bit msb_first);
        logic [DATA_W-1:0] word;
        word = arrival;
        if (msb_first) begin
            for (int k = 0; k < DATA_W; k++) begin
                word[DATA_W-1-k] = arrival[k];
            end
        end
        return word;
    endfunction

    // High when data plus parity bit do not have an even number of ones.
    function automatic logic even_par_err(input logic [DATA_W-1:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction

endpackage

// File: rtl/serial_nibble_shifter.sv
// Serial front end: counts strobed bits, shifts data bits in and flags frame
// completion together with the assembled word and its parity check.
module serial_nibble_shifter
    import serial_nibble_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_vld,
    input  logic              din,
    output logic              frame_done,
    output logic [DATA_W-1:0] word,
    output logic              par_err
);

    localparam int FL = frame_len(PARITY_EN);

    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shifted;
    logic              last_bit;
    logic              data_bit;

    always_comb begin
        last_bit = (cnt_q == 3'(FL - 1));
        data_bit = (cnt_q < 3'(DATA_W));
        // Shift right so that after DATA_W bits, bit k holds the k-th arrival.
        shifted  = {din, shift_q[DATA_W-1:1]};
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        if (din_vld) begin
            cnt_d = last_bit ? 3'd0 : cnt_q + 3'd1;
            if (data_bit) begin
                shift_d = shifted;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Without parity the final bit is still on din, so take the word from the shift input.
    assign frame_done = din_vld && last_bit;
    assign word       = order_bits(PARITY_EN ? shift_q : shifted, MSB_FIRST);
    assign par_err    = PARITY_EN ? even_par_err(shift_q, din) : 1'b0;

endmodule

// File: rtl/serial_nibble_rx.sv
// Serial nibble receiver: shifter front end plus a single-entry output buffer
// that drops (and flags) frames arriving while an unaccepted word is held.
module serial_nibble_rx
    import serial_nibble_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_vld,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              par_err,
    output logic              ovf
);

    logic              frame_done;
    logic [DATA_W-1:0] word;
    logic              word_par_err;

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              par_err_q, par_err_d;
    logic              ovf_q, ovf_d;
    logic              handshake;
    logic              load;

    serial_nibble_shifter #(
        .MSB_FIRST (MSB_FIRST),
        .PARITY_EN (PARITY_EN)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_vld    (din_vld),
        .din        (din),
        .frame_done (frame_done),
        .word       (word),
        .par_err    (word_par_err)
    );

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        par_err_d = par_err_q;
        ovf_d     = 1'b0;
        load      = 1'b0;
        handshake = (state_q == FULL) && dout_rdy;
        unique case (state_q)
            EMPTY: begin
                if (frame_done) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (frame_done) begin
                    // A word leaving this cycle frees the slot for the new one.
                    if (handshake) begin
                        load = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (handshake) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            dout_d    = word;
            par_err_d = word_par_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            dout_q    <= '0;
            par_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            par_err_q <= par_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = (state_q == FULL);
    assign par_err  = par_err_q;
    assign ovf      = ovf_q;

endmodule
